mem_wb_stage: RTL and testbench

- Writeback stage of the 16-bit pipelined core, directly downstream of the MEM stage.
- Latches MEM's results (wb, we, instruction, ret_addr) into the MEM/WB pipeline register and owns the 16x16 register file.
- Provides two bypassed read ports to decode, forwarding data to execute, and the RET pc-redirect.
- Counts retired instructions.

---
 rtl/mem_wb_stage_pkg.sv | 33 +++
 rtl/mem_wb_stage_reg_file.sv | 39 +++
 rtl/mem_wb_stage.sv | 102 ++++++++++
 tb/tb_mem_wb_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the writeback stage: opcode encodings, register-file
// geometry and the stack-pointer register used by CALL/RET.
package mem_wb_stage_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 16;
  localparam int REG_AW = 4;
  localparam int SP_REG = 15;
  localparam int CNT_W  = 16;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_B    = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_CALL = 4'hC;
  localparam logic [3:0] OP_RET  = 4'hD;

  // CALL and RET always target the stack pointer regardless of the rd field.
  function automatic logic [REG_AW-1:0] dest_reg(input logic [3:0] opcode,
                                                 input logic [REG_AW-1:0] rd);
    if (opcode == OP_CALL || opcode == OP_RET) return REG_AW'(SP_REG);
    return rd;
  endfunction

endpackage

// File: rtl/mem_wb_stage_reg_file.sv
// Architectural register file: one write port, two combinational read ports
// with write-through bypass; R0 is hardwired to zero.
module mem_wb_stage_reg_file
  import mem_wb_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (wr_en && wr_addr != '0) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // A write landing this edge is already visible to decode in the same cycle.
  assign rs_data = (rs_addr == '0) ? '0 :
                   (wr_en && wr_addr == rs_addr) ? wr_data : regs_q[rs_addr];
  assign rt_data = (rt_addr == '0) ? '0 :
                   (wr_en && wr_addr == rt_addr) ? wr_data : regs_q[rt_addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register plus writeback: destination decode, forwarding,
// RET redirect and retired-instruction counter around the register file.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic [15:0]       mem_instr,
  input  logic [15:0]       mem_wb,
  input  logic              mem_we,
  input  logic [15:0]       mem_ret_addr,
  input  logic              stall,
  input  logic              flush,
  input  logic [3:0]        rs_addr,
  input  logic [3:0]        rt_addr,
  output logic [15:0]       rs_data,
  output logic [15:0]       rt_data,
  output logic              fwd_valid,
  output logic [3:0]        fwd_rd,
  output logic [15:0]       fwd_data,
  output logic              redirect_valid,
  output logic [15:0]       redirect_pc,
  output logic [CNT_W-1:0]  retired_count
);

  logic             valid_q, valid_d;
  logic [3:0]       op_q, op_d;
  logic [3:0]       rd_q, rd_d;
  logic [15:0]      wb_q, wb_d;
  logic             we_q, we_d;
  logic [15:0]      ret_q, ret_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             capture;
  logic [3:0]       dest;
  logic             wr_en;

  // Stall and flush both turn this edge into a bubble; payload simply holds.
  always_comb begin
    capture = mem_valid & ~stall & ~flush;
    valid_d = capture;
    op_d    = op_q;
    rd_d    = rd_q;
    wb_d    = wb_q;
    we_d    = we_q;
    ret_d   = ret_q;
    if (capture) begin
      op_d  = mem_instr[15:12];
      rd_d  = mem_instr[11:8];
      wb_d  = mem_wb;
      we_d  = mem_we;
      ret_d = mem_ret_addr;
    end
    count_d = valid_q ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      rd_q    <= '0;
      wb_q    <= '0;
      we_q    <= 1'b0;
      ret_q   <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      wb_q    <= wb_d;
      we_q    <= we_d;
      ret_q   <= ret_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    dest           = dest_reg(op_q, rd_q);
    wr_en          = valid_q & we_q & (dest != '0);
    fwd_valid      = wr_en;
    fwd_rd         = wr_en ? dest : '0;
    fwd_data       = wr_en ? wb_q : '0;
    redirect_valid = valid_q & (op_q == OP_RET);
    redirect_pc    = redirect_valid ? ret_q : '0;
  end

  assign retired_count = count_q;

  mem_wb_stage_reg_file u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (dest),
    .wr_data (wb_q),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table with a register-file model
// and an expected-output queue, followed by reset and counter-wrap sequences.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic [15:0] mem_instr;
  logic [15:0] mem_wb;
  logic        mem_we;
  logic [15:0] mem_ret_addr;
  logic        stall;
  logic        flush;
  logic [3:0]  rs_addr;
  logic [3:0]  rt_addr;
  logic [15:0] rs_data;
  logic [15:0] rt_data;
  logic        fwd_valid;
  logic [3:0]  fwd_rd;
  logic [15:0] fwd_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] retired_count;

  mem_wb_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_valid      (mem_valid),
    .mem_instr      (mem_instr),
    .mem_wb         (mem_wb),
    .mem_we         (mem_we),
    .mem_ret_addr   (mem_ret_addr),
    .stall          (stall),
    .flush          (flush),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .fwd_valid      (fwd_valid),
    .fwd_rd         (fwd_rd),
    .fwd_data       (fwd_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .retired_count  (retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] instr;
    logic [15:0] wb;
    logic        we;
    logic [15:0] ret;
    logic        stall;
    logic        flush;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic        e_fv;
    logic [3:0]  e_rd;
    logic [15:0] e_fd;
    logic        e_rv;
    logic [15:0] e_pc;
  } vec_t;

  typedef struct {
    logic        fv;
    logic [3:0]  rd;
    logic [15:0] fd;
    logic        rv;
    logic [15:0] pc;
  } exp_t;

  int compared   = 0;
  int mismatched = 0;

  exp_t        sb[$];
  logic [15:0] m_regs [16];
  logic        m_pend_valid;
  logic        m_pend_weff;
  logic [3:0]  m_pend_rd;
  logic [15:0] m_pend_data;
  logic [15:0] m_count;

  vec_t vecs[18];

  function automatic vec_t mk(input logic v, input logic [3:0] op, input logic [3:0] rd,
                              input logic [15:0] wb, input logic we, input logic [15:0] ret,
                              input logic st, input logic fl, input logic [3:0] rs,
                              input logic [3:0] rt, input logic efv, input logic [3:0] erd,
                              input logic [15:0] efd, input logic erv, input logic [15:0] epc);
    vec_t r;
    r.valid = v;   r.instr = {op, rd, 8'h00}; r.wb = wb; r.we = we; r.ret = ret;
    r.stall = st;  r.flush = fl; r.rs = rs; r.rt = rt;
    r.e_fv = efv;  r.e_rd = erd; r.e_fd = efd; r.e_rv = erv; r.e_pc = epc;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [3:0] a);
    if (a == 4'd0) return 16'h0000;
    if (m_pend_weff && m_pend_rd == a) return m_pend_data;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    m_pend_valid = 1'b0;
    m_pend_weff  = 1'b0;
    m_pend_rd    = 4'd0;
    m_pend_data  = 16'h0000;
    m_count      = 16'h0000;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    logic [3:0] d;
    @(negedge clk);
    mem_valid    = v.valid;
    mem_instr    = v.instr;
    mem_wb       = v.wb;
    mem_we       = v.we;
    mem_ret_addr = v.ret;
    stall        = v.stall;
    flush        = v.flush;
    rs_addr      = v.rs;
    rt_addr      = v.rt;
    #1;
    checkOutput($sformatf("rs_data[%0d]", idx), {16'h0, rs_data}, {16'h0, model_read(v.rs)});
    checkOutput($sformatf("rt_data[%0d]", idx), {16'h0, rt_data}, {16'h0, model_read(v.rt)});
    e.fv = v.e_fv; e.rd = v.e_rd; e.fd = v.e_fd; e.rv = v.e_rv; e.pc = v.e_pc;
    sb.push_back(e);
    @(posedge clk);
    if (m_pend_weff) m_regs[m_pend_rd] = m_pend_data;
    if (m_pend_valid) m_count = m_count + 16'd1;
    m_pend_valid = v.valid & ~v.stall & ~v.flush;
    d = (v.instr[15:12] == OP_CALL || v.instr[15:12] == OP_RET) ? 4'd15 : v.instr[11:8];
    m_pend_weff = m_pend_valid & v.we & (d != 4'd0);
    m_pend_rd   = d;
    m_pend_data = v.wb;
    #1;
    if (sb.size() == 0) begin
      checkOutput($sformatf("scoreboard_empty[%0d]", idx), 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      checkOutput($sformatf("fwd_valid[%0d]", idx), {31'h0, fwd_valid}, {31'h0, got.fv});
      checkOutput($sformatf("fwd_rd[%0d]", idx), {28'h0, fwd_rd}, {28'h0, got.rd});
      checkOutput($sformatf("fwd_data[%0d]", idx), {16'h0, fwd_data}, {16'h0, got.fd});
      checkOutput($sformatf("redirect_valid[%0d]", idx), {31'h0, redirect_valid}, {31'h0, got.rv});
      checkOutput($sformatf("redirect_pc[%0d]", idx), {16'h0, redirect_pc}, {16'h0, got.pc});
    end
    checkOutput($sformatf("retired_count[%0d]", idx), {16'h0, retired_count}, {16'h0, m_count});
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //          v  op       rd  wb       we ret      st fl rs  rt   efv erd  efd      erv epc
    vecs[0]  = mk(1, OP_ADD,  3, 16'h000A, 1, 16'h0000, 0, 0, 3,  0,  1,  3,  16'h000A, 0, 16'h0000);
    vecs[1]  = mk(0, OP_ADD,  0, 16'h0000, 0, 16'h0000, 0, 0, 3,  0,  0,  0,  16'h0000, 0, 16'h0000);
    vecs[2]  = mk(1, OP_LW,   1, 16'h0A0A, 1, 16'h0000, 0, 0, 3,  1,  1,  1,  16'h0A0A, 0, 16'h0000);
    vecs[3]  = mk(1, OP_SW,   2, 16'h5555, 0, 16'h0000, 0, 0, 0,  1,  0,  0,  16'h0000, 0, 16'h0000);
    vecs[4]  = mk(1, OP_CALL, 7, 16'h0001, 1, 16'h0000, 0, 0, 2,  1,  1,  15, 16'h0001, 0, 16'h0000);
    vecs[5]  = mk(1, OP_RET,  0, 16'h0006, 1, 16'hABCD, 0, 0, 15, 2,  1,  15, 16'h0006, 1, 16'hABCD);
    vecs[6]  = mk(0, OP_ADD,  0, 16'h0000, 0, 16'h0000, 0, 0, 15, 0,  0,  0,  16'h0000, 0, 16'h0000);
    vecs[7]  = mk(1, OP_ADD,  0, 16'hFFFF, 1, 16'h0000, 0, 0, 15, 0,  0,  0,  16'h0000, 0, 16'h0000);
    vecs[8]  = mk(0, OP_ADD,  0, 16'h0000, 0, 16'h0000, 0, 0, 0,  0,  0,  0,  16'h0000, 0, 16'h0000);
    vecs[9]  = mk(1, OP_ADD,  5, 16'h1234, 1, 16'h0000, 1, 0, 5,  0,  0,  0,  16'h0000, 0, 16'h0000);
    vecs[10] = mk(1, OP_ADD,  5, 16'h1234, 1, 16'h0000, 0, 1, 5,  0,  0,  0,  16'h0000, 0, 16'h0000);
    vecs[11] = mk(1, OP_ADD,  5, 16'h1234, 1, 16'h0000, 1, 1, 5,  0,  0,  0,  16'h0000, 0, 16'h0000);
    vecs[12] = mk(1, OP_ADD,  5, 16'h1234, 1, 16'h0000, 0, 0, 5,  0,  1,  5,  16'h1234, 0, 16'h0000);
    vecs[13] = mk(0, OP_ADD,  0, 16'h0000, 0, 16'h0000, 0, 0, 5,  3,  0,  0,  16'h0000, 0, 16'h0000);
    vecs[14] = mk(0, OP_ADD,  0, 16'h0000, 0, 16'h0000, 0, 0, 5,  1,  0,  0,  16'h0000, 0, 16'h0000);
    vecs[15] = mk(1, 4'hF,    6, 16'hBEEF, 1, 16'h0000, 0, 0, 15, 0,  1,  6,  16'hBEEF, 0, 16'h0000);
    vecs[16] = mk(1, OP_B,    7, 16'h4444, 0, 16'h2222, 0, 0, 6,  7,  0,  0,  16'h0000, 0, 16'h0000);
    vecs[17] = mk(0, OP_ADD,  0, 16'h0000, 0, 16'h0000, 0, 0, 6,  7,  0,  0,  16'h0000, 0, 16'h0000);

    rst_n = 1'b0;
    mem_valid = 1'b0; mem_instr = '0; mem_wb = '0; mem_we = 1'b0; mem_ret_addr = '0;
    stall = 1'b0; flush = 1'b0; rs_addr = 4'd3; rt_addr = 4'd15;
    model_reset();
    #12;
    checkOutput("reset_fwd_valid", {31'h0, fwd_valid}, 32'h0);
    checkOutput("reset_redirect_valid", {31'h0, redirect_valid}, 32'h0);
    checkOutput("reset_count", {16'h0, retired_count}, 32'h0);
    checkOutput("reset_rs_data", {16'h0, rs_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] running vector table");
    for (int i = 0; i < 18; i++) applyStimulus(vecs[i], i);

    $display("[TB] reset with a pending write");
    @(negedge clk);
    mem_valid = 1'b1; mem_instr = {OP_ADD, 4'd9, 8'h00}; mem_wb = 16'h7777; mem_we = 1'b1;
    stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("pre_reset_fwd_valid", {31'h0, fwd_valid}, 32'h1);
    mem_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    rs_addr = 4'd9;
    rt_addr = 4'd3;
    #1;
    checkOutput("midreset_fwd_valid", {31'h0, fwd_valid}, 32'h0);
    checkOutput("midreset_fwd_rd", {28'h0, fwd_rd}, 32'h0);
    checkOutput("midreset_fwd_data", {16'h0, fwd_data}, 32'h0);
    checkOutput("midreset_count", {16'h0, retired_count}, 32'h0);
    checkOutput("midreset_rs_data", {16'h0, rs_data}, 32'h0);
    checkOutput("midreset_rt_data", {16'h0, rt_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postreset_r9", {16'h0, rs_data}, 32'h0);
    checkOutput("postreset_count", {16'h0, retired_count}, 32'h0);

    $display("[TB] retired counter wrap");
    @(negedge clk);
    mem_valid = 1'b1; mem_instr = {OP_SW, 4'd2, 8'h00}; mem_we = 1'b0; mem_wb = 16'h0000;
    repeat (65536) @(posedge clk);
    #1;
    checkOutput("count_at_ffff", {16'h0, retired_count}, 32'h0000FFFF);
    @(negedge clk);
    mem_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("count_wrapped", {16'h0, retired_count}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("count_idle_after_wrap", {16'h0, retired_count}, 32'h0);
    rs_addr = 4'd2;
    #1;
    checkOutput("sw_no_write_r2", {16'h0, rs_data}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
